// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared segment patterns and index-width helpers for the multiplexed FND scanner.
// Patterns are active-low {dp,g,f,e,d,c,b,a}; bit 7 set means the dot is off.
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Any of A-E decodes to blank; A is used internally to force a dark digit.
    localparam logic [3:0] CODE_BLANK = 4'hA;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Display-side bundle: BCD pages and display controls in, FND pin drive out.
interface fnd_scan_if #(
    parameter int ND = 4,
    parameter int NP = 2,
    parameter int PW = 1,
    parameter int BW = 3
);
    logic [4*ND*NP-1:0] bcd_in;
    logic [ND*NP-1:0]   dot_in;
    logic [PW-1:0]      page_sel;
    logic               blank_lz;
    logic [ND-1:0]      blink_en;
    logic [BW-1:0]      brightness;
    logic [ND-1:0]      fnd_com;
    logic [7:0]         fnd_data;
    logic               frame_start;

    modport master (
        output bcd_in, dot_in, page_sel, blank_lz, blink_en, brightness,
        input  fnd_com, fnd_data, frame_start
    );

    modport slave (
        input  bcd_in, dot_in, page_sel, blank_lz, blink_en, brightness,
        output fnd_com, fnd_data, frame_start
    );
endinterface

// File: rtl/fnd_scan_ctrl_seg_decode.sv
// BCD/code nibble plus dot to active-low 7-segment pattern; F is a dash, A-E are blank.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dot,
    output logic [7:0] seg
);

    always_comb begin
        case (code)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hF:    seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
        if (dot) seg[7] = 1'b0;
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode FND scanner: one digit slot per DIV clocks, page latched per frame,
// leading-zero blanking, per-digit blink and PWM brightness, all outputs registered.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1_000,
    parameter int NUM_DIGITS = 4,
    parameter int NUM_PAGES  = 2,
    parameter int BRIGHT_W   = 3,
    parameter int BLINK_DIV  = 250
) (
    input  logic     clk,
    input  logic     reset,
    fnd_scan_if.slave bus
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PHW = clog2(DIV + 1);   // wide enough to hold on_time == DIV
    localparam int DW  = idx_w(NUM_DIGITS);
    localparam int PW  = idx_w(NUM_PAGES);
    localparam int BCW = idx_w(BLINK_DIV);

    logic [PHW-1:0]        phase_q, phase_d, on_time_q, on_time_d, on_time_calc;
    logic [DW-1:0]         idx_q, idx_d;
    logic [PW-1:0]         page_q, page_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic                  bph_q, bph_d;
    logic [NUM_DIGITS-1:0] fnd_com_q, fnd_com_d;
    logic [7:0]            fnd_data_q, fnd_data_d;
    logic                  frame_q, frame_d;

    logic                       tick, lz_run, blink_off;
    logic [NUM_DIGITS-1:0][3:0] pg_code;
    logic [NUM_DIGITS-1:0]      pg_dot, lz_mask, one_hot;
    logic [3:0]                 dec_code;
    logic                       dec_dot;
    logic [7:0]                 seg;

    assign on_time_calc = PHW'(((32'(bus.brightness) + 32'd1) * DIV) >> BRIGHT_W);

    // Counters, page latch and blink phase all advance on the slot tick.
    always_comb begin
        tick      = (phase_q == PHW'(DIV - 1));
        phase_d   = tick ? '0 : phase_q + 1'b1;
        idx_d     = idx_q;
        page_d    = page_q;
        on_time_d = on_time_q;
        bcnt_d    = bcnt_q;
        bph_d     = bph_q;
        if (tick) begin
            on_time_d = on_time_calc;
            if (idx_q == DW'(NUM_DIGITS - 1)) begin
                idx_d  = '0;
                page_d = (32'(bus.page_sel) < NUM_PAGES) ? bus.page_sel : '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
            if (bcnt_q == BCW'(BLINK_DIV - 1)) begin
                bcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // Leading-zero run from the top digit down; digit 0 is never part of it.
    always_comb begin
        lz_run  = bus.blank_lz;
        lz_mask = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            pg_code[d] = bus.bcd_in[(32'(page_q) * NUM_DIGITS + d) * 4 +: 4];
            pg_dot[d]  = bus.dot_in[32'(page_q) * NUM_DIGITS + d];
        end
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            lz_run     = lz_run && (pg_code[d] == 4'h0);
            lz_mask[d] = lz_run;
        end
    end

    always_comb begin
        blink_off = bus.blink_en[idx_q] & bph_q;
        dec_code  = (blink_off || lz_mask[idx_q]) ? CODE_BLANK : pg_code[idx_q];
        dec_dot   = pg_dot[idx_q] & ~blink_off;
        one_hot   = '0;
        one_hot[idx_q] = 1'b1;
        fnd_com_d  = (phase_q < on_time_q) ? ~one_hot : '1;
        fnd_data_d = seg;
        frame_d    = (phase_q == '0) && (idx_q == '0);
    end

    fnd_seg_decode u_dec (
        .code (dec_code),
        .dot  (dec_dot),
        .seg  (seg)
    );

    // on_time loads from the live brightness in reset so the first slot is lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= '0;
            idx_q      <= '0;
            page_q     <= '0;
            on_time_q  <= on_time_calc;
            bcnt_q     <= '0;
            bph_q      <= 1'b0;
            fnd_com_q  <= '1;
            fnd_data_q <= SEG_BLANK;
            frame_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            page_q     <= page_d;
            on_time_q  <= on_time_d;
            bcnt_q     <= bcnt_d;
            bph_q      <= bph_d;
            fnd_com_q  <= fnd_com_d;
            fnd_data_q <= fnd_data_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.fnd_com     = fnd_com_q;
    assign bus.fnd_data    = fnd_data_q;
    assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with DIV=10, four digits, two pages, BLINK_DIV=2.
module tb_fnd_scan_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    fnd_scan_if #(.ND(4), .NP(2), .PW(1), .BW(3)) bus ();

    fnd_scan_ctrl #(
        .CLK_HZ     (1000),
        .SCAN_HZ    (100),
        .NUM_DIGITS (4),
        .NUM_PAGES  (2),
        .BRIGHT_W   (3),
        .BLINK_DIV  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected patterns: page0 shows 1,2,3,4 (d3..d0), page1 shows 5,6,7,8.
    logic [7:0] pg0_seg [4];
    logic [7:0] pg1_seg [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ends #1 after the first edge out of reset: outputs then show slot 0, phase 0.
    task automatic restart();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (bus.fnd_com !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_com: got %b expected %b", bus.fnd_com, 4'hF);
        end
        n_chk++;
        if (bus.fnd_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected %h", bus.fnd_data, 8'hFF);
        end
        n_chk++;
        if (bus.frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame: got %b expected 0", bus.frame_start);
        end
    endtask

    task automatic test_scan();
        logic [3:0] ec;
        int         slot;
        bus.brightness = 3'd7;
        restart();
        for (int n = 0; n <= 40; n++) begin
            slot = (n / 10) % 4;
            ec = ~(4'b0001 << slot);
            n_chk++;
            if (bus.fnd_com !== ec) begin
                n_fail++;
                $display("FAIL scan_com n=%0d: got %b expected %b", n, bus.fnd_com, ec);
            end
            n_chk++;
            if (bus.fnd_data !== pg0_seg[slot]) begin
                n_fail++;
                $display("FAIL scan_data n=%0d: got %h expected %h", n, bus.fnd_data, pg0_seg[slot]);
            end
            n_chk++;
            if (bus.frame_start !== (n % 40 == 0)) begin
                n_fail++;
                $display("FAIL scan_frame n=%0d: got %b expected %b", n, bus.frame_start, (n % 40 == 0));
            end
            step();
        end
    endtask

    task automatic test_brightness();
        logic [2:0] br   [2];
        int         on_c [2];
        logic [3:0] ec;
        int         slot;
        br   = '{3'd0, 3'd3};
        on_c = '{1, 5};
        for (int c = 0; c < 2; c++) begin
            bus.brightness = br[c];
            restart();
            for (int n = 0; n < 40; n++) begin
                slot = n / 10;
                ec = ((n % 10) < on_c[c]) ? ~(4'b0001 << slot) : 4'hF;
                n_chk++;
                if (bus.fnd_com !== ec) begin
                    n_fail++;
                    $display("FAIL bright%0d_com n=%0d: got %b expected %b", br[c], n, bus.fnd_com, ec);
                end
                n_chk++;
                if (bus.fnd_data !== pg0_seg[slot]) begin
                    n_fail++;
                    $display("FAIL bright%0d_data n=%0d: got %h expected %h", br[c], n, bus.fnd_data, pg0_seg[slot]);
                end
                step();
            end
        end
        bus.brightness = 3'd7;
    endtask

    task automatic test_leading_zero();
        logic [15:0]     bcd [4];
        logic [3:0]      dot [4];
        logic [3:0][7:0] exp [4];
        int              slot;
        bcd = '{16'h0007, 16'h0000, 16'h0000, 16'hFA09};
        dot = '{4'b0000,  4'b0000,  4'b0100,  4'b0000};
        exp[0] = {8'hFF, 8'hFF, 8'hFF, 8'hF8};
        exp[1] = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
        exp[2] = {8'hFF, 8'h7F, 8'hFF, 8'hC0};
        exp[3] = {8'hBF, 8'hFF, 8'hC0, 8'h90};
        bus.blank_lz = 1'b1;
        bus.bcd_in   = {16'h5678, bcd[0]};
        restart();
        for (int c = 0; c < 4; c++) begin
            bus.bcd_in = {16'h5678, bcd[c]};
            bus.dot_in = {4'b0000, dot[c]};
            for (int k = 0; k < 40; k++) begin
                if (k % 10 == 5) begin
                    slot = k / 10;
                    n_chk++;
                    if (bus.fnd_data !== exp[c][slot]) begin
                        n_fail++;
                        $display("FAIL lz case%0d d%0d: got %h expected %h", c, slot, bus.fnd_data, exp[c][slot]);
                    end
                end
                step();
            end
        end
        bus.blank_lz = 1'b0;
        bus.dot_in   = '0;
        bus.bcd_in   = {16'h5678, 16'h1234};
    endtask

    task automatic test_page_switch();
        logic [7:0] ed;
        int         slot;
        bus.page_sel = 1'b0;
        restart();
        for (int n = 0; n < 80; n++) begin
            slot = (n / 10) % 4;
            if (n % 10 == 5) begin
                ed = (n < 40) ? pg0_seg[slot] : pg1_seg[slot];
                n_chk++;
                if (bus.fnd_data !== ed) begin
                    n_fail++;
                    $display("FAIL page n=%0d: got %h expected %h", n, bus.fnd_data, ed);
                end
            end
            if (n == 40) begin
                n_chk++;
                if (bus.frame_start !== 1'b1 || bus.fnd_data !== pg1_seg[0]) begin
                    n_fail++;
                    $display("FAIL page_frame: got fs=%b data=%h expected fs=1 data=%h",
                             bus.frame_start, bus.fnd_data, pg1_seg[0]);
                end
            end
            if (n == 25) bus.page_sel = 1'b1;
            step();
        end
        bus.page_sel = 1'b0;
    endtask

    task automatic test_blink();
        logic [3:0] en [2];
        logic [7:0] ed;
        logic [3:0] ec;
        logic       ph;
        int         slot;
        en = '{4'b1111, 4'b0100};
        for (int c = 0; c < 2; c++) begin
            bus.blink_en = en[c];
            restart();
            for (int n = 0; n < 80; n++) begin
                if (n % 10 == 5) begin
                    slot = (n / 10) % 4;
                    ph   = ((n / 20) % 2) == 1;
                    ed   = (en[c][slot] && ph) ? 8'hFF : pg0_seg[slot];
                    ec   = ~(4'b0001 << slot);
                    n_chk++;
                    if (bus.fnd_data !== ed || bus.fnd_com !== ec) begin
                        n_fail++;
                        $display("FAIL blink en=%b n=%0d: got com=%b data=%h expected com=%b data=%h",
                                 en[c], n, bus.fnd_com, bus.fnd_data, ec, ed);
                    end
                end
                step();
            end
        end
        bus.blink_en = '0;
    endtask

    task automatic test_reset_mid_frame();
        restart();
        repeat (25) step();
        reset = 1'b1;
        step();
        n_chk++;
        if (bus.fnd_com !== 4'hF || bus.fnd_data !== 8'hFF || bus.frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out: got com=%b data=%h fs=%b expected com=1111 data=ff fs=0",
                     bus.fnd_com, bus.fnd_data, bus.frame_start);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        n_chk++;
        if (bus.fnd_com !== 4'b1110 || bus.fnd_data !== pg0_seg[0] || bus.frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_restart: got com=%b data=%h fs=%b expected com=1110 data=%h fs=1",
                     bus.fnd_com, bus.fnd_data, bus.frame_start, pg0_seg[0]);
        end
        repeat (10) step();
        n_chk++;
        if (bus.fnd_com !== 4'b1101 || bus.fnd_data !== pg0_seg[1]) begin
            n_fail++;
            $display("FAIL midreset_d1: got com=%b data=%h expected com=1101 data=%h",
                     bus.fnd_com, bus.fnd_data, pg0_seg[1]);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        pg0_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        pg1_seg = '{8'h80, 8'hF8, 8'h82, 8'h92};
        reset          = 1'b1;
        bus.bcd_in     = {16'h5678, 16'h1234};
        bus.dot_in     = '0;
        bus.page_sel   = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.blink_en   = '0;
        bus.brightness = 3'd7;

        test_reset();
        test_scan();
        test_brightness();
        test_leading_zero();
        test_page_switch();
        test_blink();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
